// File: rtl/interrupt_pending_latch_pkg.sv
// Shared definitions for the interrupt pending latch: line count, mask reset value
// and service FSM state encoding.
package interrupt_pending_latch_pkg;

   localparam int NUM_LINES = 4;
   localparam logic [NUM_LINES-1:0] MASK_RST = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_SETTLE  = 2'd2
   } svc_state_t;

endpackage

// File: rtl/interrupt_pending_latch_if.sv
// Request/mask/acknowledge bus of the interrupt pending latch.
// The slave modport is the latch; the master modport is the requester/consumer side.
interface interrupt_pending_latch_if;
   import interrupt_pending_latch_pkg::*;

   logic [NUM_LINES-1:0] req;
   logic                 mask_wr;
   logic [NUM_LINES-1:0] mask_in;
   logic                 ack;
   logic [1:0]           ack_idx;
   logic                 ovf_clr;
   logic [NUM_LINES-1:0] pend;
   logic                 irq;
   logic [NUM_LINES-1:0] ovf;

   modport master (
      output req, mask_wr, mask_in, ack, ack_idx, ovf_clr,
      input  pend, irq, ovf
   );

   modport slave (
      input  req, mask_wr, mask_in, ack, ack_idx, ovf_clr,
      output pend, irq, ovf
   );

endinterface

// File: rtl/interrupt_pending_latch_req_sync.sv
// Multi-flop synchronizer for one asynchronous request line.
// SYNC_STAGES is 2 or 3; the output is the last flop of the chain.
module req_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_sync;

   // Shift the raw line through the synchronizer chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_pending_latch.sv
// Synchronizes four request lines, latches their rising edges as pending bits and
// presents them through a mask to a service FSM. Optional PENDING_OVERFLOW_EN adds sticky overflow flags.
module interrupt_pending_latch
   import interrupt_pending_latch_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   interrupt_pending_latch_if.slave    bus
);

   logic [NUM_LINES-1:0] w_sync;
   logic [NUM_LINES-1:0] w_edge;
   logic [NUM_LINES-1:0] w_clr;
   logic [NUM_LINES-1:0] w_pending_nxt;
   logic [NUM_LINES-1:0] w_pend;
   logic                 w_ack_ok;

   logic [NUM_LINES-1:0] r_prev;
   logic [NUM_LINES-1:0] r_edge;
   logic [NUM_LINES-1:0] r_pending;
   logic [NUM_LINES-1:0] r_mask;
   svc_state_t           r_state;
   logic                 r_irq;

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_sync
      req_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_req_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .i_d   (bus.req[g]),
         .o_q   (w_sync[g])
      );
   end

   // Edge detect, ack decode and next pending value; a registered edge beats a same-cycle clear
   always_comb begin
      w_edge   = w_sync & ~r_prev;
      w_ack_ok = 1'b0;
      w_clr    = 4'b0000;
      if ((r_state == ST_PRESENT) && bus.ack) begin
         w_ack_ok = 1'b1;
         w_clr    = 4'b0001 << bus.ack_idx;
      end else begin
         w_ack_ok = 1'b0;
         w_clr    = 4'b0000;
      end
      w_pending_nxt = (r_pending & ~w_clr) | r_edge;
   end

   assign w_pend   = r_pending & r_mask;
   assign bus.pend = w_pend;
   assign bus.irq  = r_irq;

   // Edge flops, pending accumulator and mask register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev    <= 4'b0000;
         r_edge    <= 4'b0000;
         r_pending <= 4'b0000;
         r_mask    <= MASK_RST;
      end else begin
         r_prev    <= w_sync;
         r_edge    <= w_edge;
         r_pending <= w_pending_nxt;
         if (bus.mask_wr) begin
            r_mask <= bus.mask_in;
         end else begin
            r_mask <= r_mask;
         end
      end
   end

   // Service FSM with registered irq, high only while a request is presented
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_irq   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pend != 4'b0000) begin
                  r_state <= ST_PRESENT;
                  r_irq   <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_irq   <= 1'b0;
               end
            end
            ST_PRESENT: begin
               if (w_ack_ok) begin
                  r_state <= ST_SETTLE;
                  r_irq   <= 1'b0;
               end else if (w_pend == 4'b0000) begin
                  r_state <= ST_IDLE;
                  r_irq   <= 1'b0;
               end else begin
                  r_state <= ST_PRESENT;
                  r_irq   <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (w_pend != 4'b0000) begin
                  r_state <= ST_PRESENT;
                  r_irq   <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_irq   <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_irq   <= 1'b0;
            end
         endcase
      end
   end

`ifdef PENDING_OVERFLOW_EN
   logic [NUM_LINES-1:0] w_ovf_set;
   logic [NUM_LINES-1:0] r_ovf;

   assign w_ovf_set = r_edge & r_pending & ~w_clr;

   // Sticky overflow flags; an overflow in the clearing cycle is still recorded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 4'b0000;
      end else if (bus.ovf_clr) begin
         r_ovf <= w_ovf_set;
      end else begin
         r_ovf <= r_ovf | w_ovf_set;
      end
   end

   assign bus.ovf = r_ovf;
`else
   assign bus.ovf = 4'b0000;
`endif

endmodule

// File: tb/tb_interrupt_pending_latch.sv
// Directed self-checking bench for interrupt_pending_latch (SYNC_STAGES = 2).
// Overflow expectations follow PENDING_OVERFLOW_EN as compiled.
module tb_interrupt_pending_latch;
   import interrupt_pending_latch_pkg::*;

`ifdef PENDING_OVERFLOW_EN
   localparam logic [3:0] OVF_EXP_L2 = 4'b0100;
`else
   localparam logic [3:0] OVF_EXP_L2 = 4'b0000;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   interrupt_pending_latch_if bus ();

   interrupt_pending_latch #(
      .SYNC_STAGES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      n_checks++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      bus.req     = 4'b0000;
      bus.mask_wr = 1'b0;
      bus.mask_in = 4'b0000;
      bus.ack     = 1'b0;
      bus.ack_idx = 2'd0;
      bus.ovf_clr = 1'b0;

      // Reset state
      tick(2);
      check("rst_pend", bus.pend, 4'b0000);
      check("rst_irq", {3'b000, bus.irq}, 4'b0000);
      check("rst_ovf", bus.ovf, 4'b0000);
      rst_n = 1'b1;
      tick(1);

      // One-cycle pulse on req[2]: pend after SYNC_STAGES+2 edges, irq one later
      bus.req = 4'b0100;
      tick(1);
      bus.req = 4'b0000;
      tick(2);
      check("lat_pend_early", bus.pend, 4'b0000);
      tick(1);
      check("lat_pend", bus.pend, 4'b0100);
      check("lat_irq_low", {3'b000, bus.irq}, 4'b0000);
      tick(1);
      check("lat_irq", {3'b000, bus.irq}, 4'b0001);
      bus.ack = 1'b1; bus.ack_idx = 2'd2;
      tick(1);
      bus.ack = 1'b0;
      check("ack2_pend", bus.pend, 4'b0000);
      check("ack2_irq", {3'b000, bus.irq}, 4'b0000);
      tick(1);
      check("ack2_idle_irq", {3'b000, bus.irq}, 4'b0000);

      // Two lines together, serviced highest first, req held high
      bus.req = 4'b1010;
      tick(4);
      check("dual_pend", bus.pend, 4'b1010);
      tick(1);
      check("dual_irq", {3'b000, bus.irq}, 4'b0001);
      bus.ack = 1'b1; bus.ack_idx = 2'd3;
      tick(1);
      bus.ack = 1'b0;
      check("ack3_pend", bus.pend, 4'b0010);
      check("settle_irq", {3'b000, bus.irq}, 4'b0000);
      tick(1);
      check("reassert_irq", {3'b000, bus.irq}, 4'b0001);
      bus.ack = 1'b1; bus.ack_idx = 2'd1;
      tick(1);
      bus.ack = 1'b0;
      check("ack1_pend", bus.pend, 4'b0000);
      tick(1);
      check("ack1_idle_irq", {3'b000, bus.irq}, 4'b0000);
      tick(4);
      check("level_once", bus.pend, 4'b0000);
      bus.req = 4'b0000;
      tick(3);

      // Ack while irq low is ignored; mask write drops irq without ack
      bus.req = 4'b0001;
      tick(4);
      check("l0_pend", bus.pend, 4'b0001);
      bus.ack = 1'b1; bus.ack_idx = 2'd0;
      tick(1);
      bus.ack = 1'b0;
      check("ack_ignored", bus.pend, 4'b0001);
      check("ack_ignored_irq", {3'b000, bus.irq}, 4'b0001);
      bus.mask_wr = 1'b1; bus.mask_in = 4'b0000;
      tick(1);
      bus.mask_wr = 1'b0;
      check("mask0_pend", bus.pend, 4'b0000);
      tick(1);
      check("mask0_irq", {3'b000, bus.irq}, 4'b0000);
      bus.mask_wr = 1'b1; bus.mask_in = 4'b1111;
      tick(1);
      bus.mask_wr = 1'b0;
      check("mask1_pend", bus.pend, 4'b0001);
      tick(1);
      check("mask1_irq", {3'b000, bus.irq}, 4'b0001);

      // New edge on req[0] coincides with ack of line 0
      bus.req = 4'b0000;
      tick(3);
      bus.req = 4'b0001;
      tick(3);
      bus.ack = 1'b1; bus.ack_idx = 2'd0;
      tick(1);
      bus.ack = 1'b0;
      check("coll_pend", bus.pend, 4'b0001);
      check("coll_ovf", bus.ovf, 4'b0000);
      tick(1);
      check("coll_irq", {3'b000, bus.irq}, 4'b0001);
      bus.ack = 1'b1; bus.ack_idx = 2'd0;
      tick(1);
      bus.ack = 1'b0;
      check("coll_ack_pend", bus.pend, 4'b0000);
      tick(1);

      // Two edges on req[2] without service
      bus.req = 4'b0100;
      tick(1);
      bus.req = 4'b0000;
      tick(2);
      bus.req = 4'b0100;
      tick(1);
      bus.req = 4'b0000;
      tick(5);
      check("ovf_pend", bus.pend, 4'b0100);
      check("ovf_set", bus.ovf, OVF_EXP_L2);
      bus.ovf_clr = 1'b1;
      tick(1);
      bus.ovf_clr = 1'b0;
      check("ovf_clr", bus.ovf, 4'b0000);

      // Reset in the middle of service
      bus.req = 4'b1111;
      tick(4);
      check("all_pend", bus.pend, 4'b1111);
      tick(1);
      check("all_irq", {3'b000, bus.irq}, 4'b0001);
      bus.mask_wr = 1'b1; bus.mask_in = 4'b0011;
      tick(1);
      bus.mask_wr = 1'b0;
      check("mask3_pend", bus.pend, 4'b0011);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_pend", bus.pend, 4'b0000);
      check("mid_rst_irq", {3'b000, bus.irq}, 4'b0000);
      check("mid_rst_ovf", bus.ovf, 4'b0000);
      tick(1);
      rst_n = 1'b1;

      // req held through reset release counts as a new edge; mask back to all-ones
      tick(3);
      check("rel_pend_early", bus.pend, 4'b0000);
      tick(1);
      check("rel_pend", bus.pend, 4'b1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
